instr_fetch_unit: RTL and testbench

- Program-counter and fetch stage that drives the 8-bit address of the combinational instruction ROM.
- Captures the returned 16-bit instruction into an IF/ID output register with a valid/ready handshake toward the decoder.
- Handles sequential fetch, stall back-pressure, branch/jump redirect with flush, and halt.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_fetch_unit_ifid_reg.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, fetch FSM states, IF/ID payload and instruction field helpers.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;

   // Payload held in the IF/ID register
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } ifid_t;

   // Instruction field slices
   function automatic logic [2:0] instr_f15_13(input logic [INSTR_W-1:0] i);
      return i[15:13];
   endfunction

   function automatic logic [2:0] instr_f12_10(input logic [INSTR_W-1:0] i);
      return i[12:10];
   endfunction

   function automatic logic [2:0] instr_f9_7(input logic [INSTR_W-1:0] i);
      return i[9:7];
   endfunction

   function automatic logic [2:0] instr_f6_4(input logic [INSTR_W-1:0] i);
      return i[6:4];
   endfunction

   function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] i);
      return i[3:0];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_ifid_reg.sv
// IF/ID output register: valid/ready slot holding instruction and its pc, with flush.
module ifid_reg
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               flush,
   input  logic               ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [ADDR_W-1:0]  in_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   logic  valid_q, valid_d;
   ifid_t data_q, data_d;

   // Flush beats load; a consumed entry with no new load empties the slot
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d      = 1'b1;
         data_d.instr = in_instr;
         data_d.pc    = in_pc;
      end else if (ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid     = valid_q;
   assign out_instr = data_q.instr;
   assign out_pc    = data_q.pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, boot/run/halt FSM, redirect/flush and IF/ID handoff.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  instr_addr,
   input  logic [INSTR_W-1:0] instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   input  logic               halt_req,
   input  logic               ifid_ready,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        perf_fetch_cnt,
   output logic [15:0]        perf_stall_cnt
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              slot_free_c;
   logic              load_c;
   logic              flush_c;

   assign slot_free_c = !ifid_valid || ifid_ready;

   // Next-state, next-pc and IF/ID control; redirect outranks halt and stall
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load_c  = 1'b0;
      flush_c = 1'b0;
      case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (redirect_valid) begin
               pc_d    = redirect_addr;
               flush_c = 1'b1;
            end else begin
               if (slot_free_c) begin
                  load_c = 1'b1;
                  pc_d   = pc_q + ADDR_W'(1);
               end
               if (halt_req) begin
                  state_d = S_HALT;
               end
            end
         end
         S_HALT: begin
            if (redirect_valid) begin
               pc_d    = redirect_addr;
               flush_c = 1'b1;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
      halted_d = (state_d == S_HALT);
   end

   // FSM, pc and halted registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC_P;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign instr_addr = pc_q;
   assign halted     = halted_q;

   ifid_reg u_ifid_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c),
      .flush     (flush_c),
      .ready     (ifid_ready),
      .in_instr  (instr),
      .in_pc     (pc_q),
      .valid     (ifid_valid),
      .out_instr (ifid_instr),
      .out_pc    (ifid_pc)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating counters for IF/ID loads and back-pressure cycles in S_RUN
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (load_c && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if ((state_q == S_RUN) && !slot_free_c && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, stall, redirect, wrap, halt/resume, reset, counters.
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   logic               clk;
   logic               rst_n;
   logic [ADDR_W-1:0]  instr_addr;
   logic [INSTR_W-1:0] instr;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               halt_req;
   logic               ifid_ready;
   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [ADDR_W-1:0]  ifid_pc;
   logic               halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]        perf_fetch_cnt;
   logic [15:0]        perf_stall_cnt;
`endif

   logic [INSTR_W-1:0] rom [256];
   int checks;
   int errors;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_addr     (instr_addr),
      .instr          (instr),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt_req       (halt_req),
      .ifid_ready     (ifid_ready),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Combinational ROM model
   assign instr = rom[instr_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [7:0] pc, input logic [15:0] ins);
      check({tag, "_valid"}, 32'(ifid_valid), 32'd1);
      check({tag, "_pc"}, 32'(ifid_pc), 32'(pc));
      check({tag, "_instr"}, 32'(ifid_instr), 32'(ins));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) rom[i] = {8'hA5, 8'(i)};
      rom[0] = 16'h0896;
      rom[1] = 16'h1886;
      rom[2] = 16'h00A0;

      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 8'h00;
      halt_req       = 1'b0;
      ifid_ready     = 1'b1;
      step();
      step();
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_instr", 32'(ifid_instr), 32'd0);
      check("rst_pc", 32'(ifid_pc), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_addr", 32'(instr_addr), 32'd0);
      rst_n = 1'b1;

      // Boot cycle: no fetch
      step();
      check("boot_valid", 32'(ifid_valid), 32'd0);
      check("boot_addr", 32'(instr_addr), 32'd0);
      step(); check_ifid("seq0", 8'h00, 16'h0896);
      step(); check_ifid("seq1", 8'h01, 16'h1886);

      // Three stall cycles holding pc=1 entry
      ifid_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 8'h01, 16'h1886);
         check("stall_addr", 32'(instr_addr), 32'h02);
      end
      ifid_ready = 1'b1;
      step(); check_ifid("unstall2", 8'h02, 16'h00A0);
      step(); check_ifid("seq3", 8'h03, 16'hA503);

      // Redirect while stalled flushes the pending entry
      ifid_ready = 1'b0;
      step(); check_ifid("stall3", 8'h03, 16'hA503);
      redirect_valid = 1'b1;
      redirect_addr  = 8'h0D;
      step();
      check("redir_flush", 32'(ifid_valid), 32'd0);
      check("redir_addr", 32'(instr_addr), 32'h0D);
      redirect_valid = 1'b0;
      ifid_ready     = 1'b1;
      step(); check_ifid("redir_tgt", 8'h0D, 16'hA50D);

      // Wrap-around of pc
      redirect_valid = 1'b1;
      redirect_addr  = 8'hFE;
      step();
      check("wrap_flush", 32'(ifid_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); check_ifid("wrapFE", 8'hFE, 16'hA5FE);
      step(); check_ifid("wrapFF", 8'hFF, 16'hA5FF);
      step(); check_ifid("wrap00", 8'h00, 16'h0896);
      step(); check_ifid("wrap01", 8'h01, 16'h1886);

      // Run up to pc=5, then halt
      step(); step(); step();
      check("pre_halt_addr", 32'(instr_addr), 32'h05);
      halt_req = 1'b1;
      step();
      check_ifid("halt_last", 8'h05, 16'hA505);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_addr", 32'(instr_addr), 32'h06);
      halt_req = 1'b0;
      step();
      check("halt_drain", 32'(ifid_valid), 32'd0);
      check("halt_hold", 32'(instr_addr), 32'h06);
      check("halt_still", 32'(halted), 32'd1);
      step();
      check("halt_idle", 32'(ifid_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_addr  = 8'h00;
      step();
      check("resume_halted", 32'(halted), 32'd0);
      check("resume_valid", 32'(ifid_valid), 32'd0);
      redirect_valid = 1'b0;
      step(); check_ifid("resume0", 8'h00, 16'h0896);

      // Redirect and halt together: redirect wins
      redirect_valid = 1'b1;
      redirect_addr  = 8'h10;
      halt_req       = 1'b1;
      step();
      check("both_halted", 32'(halted), 32'd0);
      check("both_addr", 32'(instr_addr), 32'h10);
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      step();
      check_ifid("both_tgt", 8'h10, 16'hA510);
      check("both_halted2", 32'(halted), 32'd0);

      // Asynchronous reset mid-operation
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(ifid_valid), 32'd0);
      check("arst_pc", 32'(ifid_pc), 32'd0);
      check("arst_addr", 32'(instr_addr), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("arst_fcnt", 32'(perf_fetch_cnt), 32'd0);
      check("arst_scnt", 32'(perf_stall_cnt), 32'd0);
`endif
      step();
      rst_n = 1'b1;

      // 10 fetches with 3 stall cycles
      step();
      check("boot2_valid", 32'(ifid_valid), 32'd0);
      for (int i = 0; i < 4; i++) step();
      check_ifid("perf_a", 8'h03, 16'hA503);
      ifid_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_ifid("perf_stall", 8'h03, 16'hA503);
      ifid_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check_ifid("perf_b", 8'h09, 16'hA509);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch", 32'(perf_fetch_cnt), 32'd10);
      check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
